// File: rtl/memory_if_pipe.sv
// Pipelined bus slave front-end for one synchronous single-port SRAM macro.
// Optional perf counters (rd/wr/err) are built when MEMORY_IF_PIPE_PERF_EN is defined.
module memory_if_pipe #(
  parameter int DWidth    = 32,
  parameter int AWidth    = 32,
  parameter int Depth     = 1024,
  parameter int RdLatency = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sel_i,
  input  logic [1:0]               trans_i,
  input  logic                     ready_i,
  input  logic                     write_i,
  input  logic [1:0]               size_i,
  input  logic [AWidth-1:0]        addr_i,
  input  logic [DWidth-1:0]        wdata_i,
  input  logic [DWidth-1:0]        rdata_i,
  output logic                     cen_o,
  output logic                     wen_o,
  output logic [DWidth/8-1:0]      ben_o,
  output logic [$clog2(Depth)-1:0] addr_o,
  output logic [DWidth-1:0]        wdata_o,
  output logic [DWidth-1:0]        rdata_o,
  output logic                     resp_o,
  output logic                     ready_o
`ifdef MEMORY_IF_PIPE_PERF_EN
  ,
  input  logic                     cnt_clr_i,
  output logic [15:0]              rd_cnt_o,
  output logic [15:0]              wr_cnt_o,
  output logic [15:0]              err_cnt_o
`endif
);

  localparam int BenW  = DWidth / 8;
  localparam int LaneW = $clog2(BenW);
  localparam int IdxW  = $clog2(Depth);
  localparam logic [1:0]        LatLoad = 2'(RdLatency - 1);
  localparam logic [1:0]        MaxSize = 2'(LaneW);
  localparam logic [AWidth-1:0] DepthA  = AWidth'(Depth);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StRdPend, StErr1, StErr2} state_t;

  state_t            r_state, w_state_next, w_new_state;
  logic [1:0]        r_cnt, w_cnt_next;
  // Holds the write address during its data phase, or a read parked behind that write.
  logic [IdxW-1:0]   r_idx;
  logic [LaneW-1:0]  r_lane;
  logic [1:0]        r_size;

  logic [AWidth-1:0] w_word;
  logic              w_misalign, w_err, w_open, w_accept;
  logic              w_acc_rd, w_acc_wr, w_acc_err;
  logic [BenW-1:0]   w_ben_base;

  assign w_word = addr_i >> LaneW;

  always_comb begin
    case (size_i)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = addr_i[0];
      2'd2:    w_misalign = |addr_i[1:0];
      default: w_misalign = |addr_i[2:0];
    endcase
  end

  assign w_err     = (w_word >= DepthA) | (size_i > MaxSize) | w_misalign;
  assign w_open    = (r_state == StIdle) | (r_state == StErr2) | (r_state == StWrite) |
                     ((r_state == StRead) & (r_cnt == 2'd0));
  assign w_accept  = sel_i & ready_i & trans_i[1] & w_open & ~rst_i;
  assign w_acc_rd  = w_accept & ~w_err & ~write_i;
  assign w_acc_wr  = w_accept & ~w_err & write_i;
  assign w_acc_err = w_accept & w_err;

  assign w_new_state = w_acc_err ? StErr1 : w_acc_rd ? StRead : w_acc_wr ? StWrite : StIdle;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_size  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_acc_wr || (w_acc_rd && r_state == StWrite)) begin
        r_idx  <= w_word[IdxW-1:0];
        r_lane <= addr_i[LaneW-1:0];
        r_size <= size_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle, StErr2: begin
        w_state_next = w_new_state;
        if (w_acc_rd) w_cnt_next = LatLoad;
      end
      StRead: begin
        if (r_cnt != 2'd0) begin
          w_cnt_next = r_cnt - 2'd1;
        end else begin
          w_state_next = w_new_state;
          if (w_acc_rd) w_cnt_next = LatLoad;
        end
      end
      StWrite:  w_state_next = w_acc_rd ? StRdPend : w_new_state;
      StRdPend: begin
        w_state_next = StRead;
        w_cnt_next   = LatLoad;
      end
      StErr1:   w_state_next = StErr2;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ben_base = BenW'(1);
      2'd1:    w_ben_base = BenW'(3);
      2'd2:    w_ben_base = BenW'(15);
      default: w_ben_base = '1;
    endcase
  end

  always_comb begin
    cen_o   = 1'b0;
    wen_o   = 1'b0;
    ben_o   = '0;
    addr_o  = '0;
    rdata_o = '0;
    resp_o  = 1'b0;
    ready_o = 1'b1;
    if (!rst_i) begin
      case (r_state)
        StIdle, StErr2: begin
          resp_o = (r_state == StErr2);
          if (w_acc_rd) begin
            cen_o  = 1'b1;
            addr_o = w_word[IdxW-1:0];
          end
        end
        StRead: begin
          ready_o = (r_cnt == 2'd0);
          rdata_o = rdata_i;
          if (w_acc_rd) begin
            cen_o  = 1'b1;
            addr_o = w_word[IdxW-1:0];
          end
        end
        StWrite: begin
          cen_o  = 1'b1;
          wen_o  = 1'b1;
          ben_o  = w_ben_base << r_lane;
          addr_o = r_idx;
        end
        StRdPend: begin
          ready_o = 1'b0;
          cen_o   = 1'b1;
          addr_o  = r_idx;
        end
        StErr1: begin
          resp_o  = 1'b1;
          ready_o = 1'b0;
        end
        default: ready_o = 1'b1;
      endcase
    end
  end

  // Lanes are placed by the master, so write data goes through untouched.
  assign wdata_o = wdata_i;

`ifdef MEMORY_IF_PIPE_PERF_EN
  logic [2:0]  w_perf_inc;
  logic [15:0] w_perf_cnt [3];

  assign w_perf_inc = {w_acc_err, w_acc_wr, w_acc_rd};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [15:0] r_perf;
    always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
        r_perf <= 16'd0;
      end else if (w_perf_inc[gi] && r_perf != 16'hFFFF) begin
        r_perf <= r_perf + 16'd1;
      end
    end
    assign w_perf_cnt[gi] = r_perf;
  end

  assign rd_cnt_o  = w_perf_cnt[0];
  assign wr_cnt_o  = w_perf_cnt[1];
  assign err_cnt_o = w_perf_cnt[2];
`endif

endmodule

// File: tb/tb_memory_if_pipe.sv
// Directed bench: three slaves (RdLatency 1/3/4) each with its own SRAM model, bus ready looped back.
module tb_memory_if_pipe;
  logic        clk, rst;
  logic [1:0]  trans, size;
  logic        write;
  logic [31:0] addr, wdata;
  logic        sel [3];
  logic        rdy [3];
  logic        cen [3];
  logic        wen [3];
  logic        resp [3];
  logic [3:0]  ben [3];
  logic [9:0]  addr_o [3];
  logic [31:0] wd_o [3];
  logic [31:0] rd_o [3];
  logic [31:0] rd_i [3];
`ifdef MEMORY_IF_PIPE_PERF_EN
  logic        cnt_clr;
  logic [15:0] rd_cnt [3];
  logic [15:0] wr_cnt [3];
  logic [15:0] err_cnt [3];
`endif
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int Lat = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    logic [31:0] mem [1024];
    logic [31:0] pipe [4];

    memory_if_pipe #(.RdLatency(Lat)) u_dut (
      .clk_i(clk), .rst_i(rst), .sel_i(sel[gi]), .trans_i(trans), .ready_i(rdy[gi]),
      .write_i(write), .size_i(size), .addr_i(addr), .wdata_i(wdata), .rdata_i(rd_i[gi]),
      .cen_o(cen[gi]), .wen_o(wen[gi]), .ben_o(ben[gi]), .addr_o(addr_o[gi]),
      .wdata_o(wd_o[gi]), .rdata_o(rd_o[gi]), .resp_o(resp[gi]), .ready_o(rdy[gi])
`ifdef MEMORY_IF_PIPE_PERF_EN
      , .cnt_clr_i(cnt_clr), .rd_cnt_o(rd_cnt[gi]), .wr_cnt_o(wr_cnt[gi]), .err_cnt_o(err_cnt[gi])
`endif
    );

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (cen[gi] && wen[gi]) begin
        for (int b = 0; b < 4; b++)
          if (ben[gi][b]) mem[addr_o[gi]][8*b +: 8] <= wd_o[gi][8*b +: 8];
      end
      if (cen[gi] && !wen[gi]) pipe[0] <= mem[addr_o[gi]];
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
    assign rd_i[gi] = pipe[Lat-1];
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic [1:0] tr, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a);
    for (int k = 0; k < 3; k++) sel[k] = (k == d);
    trans = tr; write = wr; size = sz; addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt(); nxt(); #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy[0]); end
    checks++; if (cen[0] !== 1'b0 || wen[0] !== 1'b0) begin errors++; $display("FAIL reset_cen_wen got=%b%b exp=00", cen[0], wen[0]); end
    checks++; if (ben[0] !== 4'h0 || resp[0] !== 1'b0) begin errors++; $display("FAIL reset_ben_resp got=%h/%b exp=0/0", ben[0], resp[0]); end
    nxt(); rst = 1'b0; #1;
    checks++; if (rdy[0] !== 1'b1 || cen[0] !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b cen=%b exp 1/0", rdy[0], cen[0]); end
  endtask

  task automatic test_l1_write_read();
    nxt(); drive(0, 2'b10, 1'b1, 2'd2, 32'h10); #1;
    checks++; if (cen[0] !== 1'b0) begin errors++; $display("FAIL wr_addr_phase_cen got=%b exp=0", cen[0]); end
    nxt(); trans = 2'b00; wdata = 32'hDEADBEEF; #1;
    checks++; if ({cen[0], wen[0], ben[0]} !== 6'b11_1111) begin errors++; $display("FAIL wr_data_phase cen/wen/ben got=%b%b%h exp=11f", cen[0], wen[0], ben[0]); end
    checks++; if (addr_o[0] !== 10'd4 || wd_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_addr_data got=%0d/%h exp=4/deadbeef", addr_o[0], wd_o[0]); end
    nxt(); drive(0, 2'b10, 1'b0, 2'd2, 32'h10); #1;
    checks++; if (cen[0] !== 1'b1 || wen[0] !== 1'b0 || addr_o[0] !== 10'd4) begin errors++; $display("FAIL rd_issue got cen=%b wen=%b addr=%0d exp 1/0/4", cen[0], wen[0], addr_o[0]); end
    nxt(); trans = 2'b00; #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rd_l1_ready got=%b exp=1", rdy[0]); end
    checks++; if (rd_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_l1_data got=%h exp=deadbeef", rd_o[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hA500_0000; exp_d[1] = 32'hA500_0001;
    nxt(); drive(1, 2'b10, 1'b0, 2'd2, 32'h0); #1;
    checks++; if (cen[1] !== 1'b1 || addr_o[1] !== 10'd0) begin errors++; $display("FAIL b2b_issue0 got cen=%b addr=%0d exp 1/0", cen[1], addr_o[1]); end
    for (int r = 0; r < 2; r++) begin
      nxt();
      if (r == 0) begin trans = 2'b11; addr = 32'h4; end else trans = 2'b00;
      #1;
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin nxt(); #1; end
        checks++; if (rdy[1] !== (k == 2)) begin errors++; $display("FAIL b2b_ready r%0d c%0d got=%b exp=%b", r, k, rdy[1], (k == 2)); end
      end
      checks++; if (rd_o[1] !== exp_d[r]) begin errors++; $display("FAIL b2b_data r%0d got=%h exp=%h", r, rd_o[1], exp_d[r]); end
      if (r == 0) begin
        checks++; if (cen[1] !== 1'b1 || addr_o[1] !== 10'd1) begin errors++; $display("FAIL b2b_issue1 got cen=%b addr=%0d exp 1/1", cen[1], addr_o[1]); end
      end
    end
  endtask

  task automatic test_wr_rd_conflict();
    int waits;
    nxt(); drive(1, 2'b10, 1'b1, 2'd2, 32'h20);
    nxt(); drive(1, 2'b10, 1'b0, 2'd2, 32'h24); wdata = 32'h1234_5678; #1;
    checks++; if ({cen[1], wen[1]} !== 2'b11 || addr_o[1] !== 10'd8) begin errors++; $display("FAIL conf_write got cen/wen=%b%b addr=%0d exp 11/8", cen[1], wen[1], addr_o[1]); end
    nxt(); trans = 2'b00; #1;
    checks++; if ({rdy[1], cen[1], wen[1]} !== 3'b010 || addr_o[1] !== 10'd9) begin errors++; $display("FAIL conf_pend got rdy/cen/wen=%b%b%b addr=%0d exp 010/9", rdy[1], cen[1], wen[1], addr_o[1]); end
    waits = 0;
    while (rdy[1] !== 1'b1 && waits < 8) begin
      waits++;
      nxt(); #1;
      if (cen[1] === 1'b1 && rdy[1] !== 1'b1) begin errors++; checks++; $display("FAIL conf_extra_access got cen=1 exp=0"); end
    end
    checks++; if (waits !== 3) begin errors++; $display("FAIL conf_waits got=%0d exp=3", waits); end
    checks++; if (rd_o[1] !== 32'hA500_0009) begin errors++; $display("FAIL conf_data got=%h exp=a5000009", rd_o[1]); end
  endtask

  task automatic test_byte_enables();
    nxt(); drive(0, 2'b10, 1'b1, 2'd0, 32'h13);
    nxt(); drive(0, 2'b10, 1'b1, 2'd1, 32'h12); #1;
    checks++; if (ben[0] !== 4'b1000) begin errors++; $display("FAIL ben_byte got=%b exp=1000", ben[0]); end
    nxt(); drive(0, 2'b10, 1'b1, 2'd1, 32'h11); #1;
    checks++; if (ben[0] !== 4'b1100) begin errors++; $display("FAIL ben_half got=%b exp=1100", ben[0]); end
    nxt(); trans = 2'b00; #1;
    checks++; if ({resp[0], rdy[0], cen[0]} !== 3'b100) begin errors++; $display("FAIL misalign_err1 got resp/rdy/cen=%b%b%b exp 100", resp[0], rdy[0], cen[0]); end
    nxt(); #1;
    checks++; if ({resp[0], rdy[0], cen[0]} !== 3'b110) begin errors++; $display("FAIL misalign_err2 got resp/rdy/cen=%b%b%b exp 110", resp[0], rdy[0], cen[0]); end
    nxt(); #1;
    checks++; if (resp[0] !== 1'b0) begin errors++; $display("FAIL misalign_after got resp=%b exp 0", resp[0]); end
  endtask

  task automatic test_range_and_idle();
    nxt(); drive(0, 2'b10, 1'b0, 2'd2, 32'd4096); #1;
    checks++; if (cen[0] !== 1'b0) begin errors++; $display("FAIL range_cen got=%b exp=0", cen[0]); end
    nxt(); trans = 2'b00; #1;
    checks++; if ({resp[0], rdy[0], cen[0]} !== 3'b100) begin errors++; $display("FAIL range_err1 got=%b%b%b exp 100", resp[0], rdy[0], cen[0]); end
    nxt(); #1;
    checks++; if ({resp[0], rdy[0], cen[0]} !== 3'b110) begin errors++; $display("FAIL range_err2 got=%b%b%b exp 110", resp[0], rdy[0], cen[0]); end
    for (int k = 0; k < 3; k++) begin
      nxt(); drive(0, (k == 0) ? 2'b00 : 2'b01, 1'b0, 2'd2, 32'h8); #1;
      checks++; if ({cen[0], rdy[0], resp[0]} !== 3'b010) begin errors++; $display("FAIL idle_busy c%0d got cen/rdy/resp=%b%b%b exp 010", k, cen[0], rdy[0], resp[0]); end
    end
  endtask

  task automatic test_reset_mid_read();
    nxt(); drive(2, 2'b10, 1'b0, 2'd2, 32'h8); #1;
    checks++; if (cen[2] !== 1'b1 || addr_o[2] !== 10'd2) begin errors++; $display("FAIL l4_issue got cen=%b addr=%0d exp 1/2", cen[2], addr_o[2]); end
    nxt(); trans = 2'b00; #1;
    checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL l4_wait got=%b exp=0", rdy[2]); end
    nxt(); rst = 1'b1; #1;
    checks++; if (cen[2] !== 1'b0 || wen[2] !== 1'b0) begin errors++; $display("FAIL rst_force got cen/wen=%b%b exp 00", cen[2], wen[2]); end
    nxt(); rst = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin nxt(); #1; end
      checks++; if ({rdy[2], cen[2], resp[2]} !== 3'b100) begin errors++; $display("FAIL rst_mid c%0d got rdy/cen/resp=%b%b%b exp 100", k, rdy[2], cen[2], resp[2]); end
    end
  endtask

`ifdef MEMORY_IF_PIPE_PERF_EN
  task automatic test_perf();
    logic [1:0]  op_wr [6] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [31:0] op_a  [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8, 32'd4096};
    checks++; if ({rd_cnt[0], wr_cnt[0], err_cnt[0]} !== 48'd0) begin errors++; $display("FAIL perf_reset got=%0d/%0d/%0d exp 0/0/0", rd_cnt[0], wr_cnt[0], err_cnt[0]); end
    for (int i = 0; i < 6; i++) begin
      nxt(); drive(0, 2'b10, op_wr[i][0], 2'd2, op_a[i]);
      nxt(); trans = 2'b00;
      nxt(); nxt();
    end
    #1;
    checks++; if (rd_cnt[0] !== 16'd3) begin errors++; $display("FAIL perf_rd got=%0d exp=3", rd_cnt[0]); end
    checks++; if (wr_cnt[0] !== 16'd2) begin errors++; $display("FAIL perf_wr got=%0d exp=2", wr_cnt[0]); end
    checks++; if (err_cnt[0] !== 16'd1) begin errors++; $display("FAIL perf_err got=%0d exp=1", err_cnt[0]); end
    nxt(); drive(0, 2'b10, 1'b0, 2'd2, 32'h0); cnt_clr = 1'b1;
    nxt(); trans = 2'b00; cnt_clr = 1'b0; #1;
    checks++; if ({rd_cnt[0], wr_cnt[0], err_cnt[0]} !== 48'd0) begin errors++; $display("FAIL perf_clr got=%0d/%0d/%0d exp 0/0/0", rd_cnt[0], wr_cnt[0], err_cnt[0]); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) sel[k] = 1'b0;
    trans = 2'b00; write = 1'b0; size = 2'd0; addr = '0; wdata = '0; rst = 1'b1;
`ifdef MEMORY_IF_PIPE_PERF_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_l1_write_read();
    test_back_to_back();
    test_wr_rd_conflict();
    test_byte_enables();
    test_range_and_idle();
    test_reset_mid_read();
`ifdef MEMORY_IF_PIPE_PERF_EN
    test_perf();
`endif
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_if_pipe.md
Name: memory_if_pipe

Overview:
- Parametrised successor of the single-port SRAM bus slave interface; it sits between the system bus and one synchronous single-port SRAM macro.
- Adds configurable read latency with bus wait states, byte-lane write enables from transfer size, and SEQ transfers.
- Adds a two-cycle ERROR response for out-of-range or misaligned accesses, and resolves write-data-phase / read-address-phase port conflicts.

Parameters:
- DWidth, 32, bus and memory data width; must be 32 or 64.
- AWidth, 32, bus address width.
- Depth, 1024, memory depth in DWidth-bit words.
- RdLatency, 1, SRAM clock cycles from read issue to valid rdata_i; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- sel_i  in  1  slave select.
- trans_i  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- ready_i  in  1  bus-level ready; the current cycle is an address phase when high.
- write_i  in  1  1 = write.
- size_i  in  2  0 byte, 1 half, 2 word, 3 dword.
- addr_i  in  AWidth  byte address.
- wdata_i  in  DWidth  write data, valid in the data phase.
- rdata_i  in  DWidth  SRAM read data.
- cen_o  out  1  SRAM chip enable.
- wen_o  out  1  SRAM write enable.
- ben_o  out  DWidth/8  SRAM byte-lane enables.
- addr_o  out  $clog2(Depth)  SRAM word address.
- wdata_o  out  DWidth  SRAM write data.
- rdata_o  out  DWidth  read data to master.
- resp_o  out  1  0 OKAY, 1 ERROR.
- ready_o  out  1  data-phase complete.

Behaviour:
- Accept condition: sel_i & ready_i & trans_i in {NONSEQ, SEQ}. IDLE and BUSY are ignored and leave the state machine in StIdle with an OKAY zero-wait response.
- Error check at accept:
  - word index addr_i >> log2(DWidth/8) >= Depth, or
  - size_i > log2(DWidth/8), or
  - addr_i not aligned to 2^size_i.
- Reset values: state StIdle, cen_o=0, wen_o=0, ben_o=0, ready_o=1, resp_o=0, internal counter 0. While rst_i is high, cen_o and wen_o are forced 0.
- States:
  - StIdle: ready_o=1, resp_o=0. On an accepted read: issue it in the same cycle (cen_o=1, wen_o=0, addr_o from addr_i), load cnt=RdLatency-1, go to StRead. On an accepted write: capture addr, size into registers, go to StWrite. On error: go to StErr1, no SRAM access.
  - StRead: ready_o=(cnt==0), rdata_o=rdata_i. Decrement cnt while nonzero. When ready_o=1, accept a new transfer exactly as in StIdle, or return to StIdle if none.
  - StWrite: cen_o=1, wen_o=1, addr_o and ben_o from the captured registers, wdata_o=wdata_i, ready_o=1. A concurrent accepted write goes to StWrite with the new capture. A concurrent accepted read is captured into the pending register and goes to StRdPend, because the SRAM port is busy. A concurrent error goes to StErr1.
  - StRdPend: ready_o=0. Issue the pending read (cen_o=1, wen_o=0), load cnt=RdLatency-1, go to StRead. This adds exactly one wait state.
  - StErr1: resp_o=1, ready_o=0. Go to StErr2.
  - StErr2: resp_o=1, ready_o=1. Accept new transfers as in StIdle.
- Byte enables:
  - byte: 1 << addr[lsb].
  - half: 2'b11 << (2 × addr[lsb:1]).
  - word: 4'hF shifted by the word lane.
  - dword: all ones.
- wdata_o passes wdata_i unshifted; the master drives the correct lanes.
- Read latency:
  - Zero wait states when RdLatency=1; RdLatency-1 wait states otherwise.
  - One additional wait state when the read follows a write data phase.
- Reset mid-transfer: the state machine returns to StIdle next cycle. Pending read and counter are discarded; no late response is issued.

Optional Feature:
- Macro: MEMORY_IF_PIPE_PERF_EN.
- When defined: adds outputs rd_cnt_o, wr_cnt_o, err_cnt_o (each 16 bits) and input cnt_clr_i.
- Counters increment once per accepted read, write, or error respectively, and saturate at 16'hFFFF.
- Counters clear on rst_i or cnt_clr_i; cnt_clr_i takes priority over an increment in the same cycle.
- When undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- RdLatency=1: write 0xDEADBEEF to 0x10, then read 0x10 → the write data phase has cen=1, wen=1, ben=4'hF, addr_o=4; the read has ready_o=1 in its first data cycle and rdata_o=0xDEADBEEF; read cost 1 cycle.
- RdLatency=3: back-to-back reads of 0x0 and 0x4 → each data phase shows ready_o low for 2 cycles, then high; second read issued in the cycle the first completes.
- Write 0x20 immediately followed by read 0x24 → StRdPend visited; read data phase has exactly RdLatency wait cycles; SRAM never sees cen with two accesses in one cycle.
- Byte write to 0x13 (size 0) → ben_o=4'b1000. Half write to 0x12 → ben_o=4'b1100. Half write to 0x11 → two-cycle ERROR, resp_o=1 both cycles, ready_o 0 then 1, cen_o stays 0.
- Read addr 4×Depth → ERROR response, no SRAM access. Then IDLE and BUSY transfers with sel_i=1 → no cen_o, ready_o=1, resp_o=0.
- Assert rst_i during a StRead wait (RdLatency=4) → next cycle StIdle, ready_o=1, cen_o=0. With MEMORY_IF_PIPE_PERF_EN defined, 3 reads, 2 writes, 1 error → rd_cnt_o=3, wr_cnt_o=2, err_cnt_o=1; cnt_clr_i → all 0.
